// File: rtl/ram_arb_pkg.sv
// Shared constants, tag types and the circular request search used by the
// two-port RAM arbiter.
package ram_arb_pkg;

    localparam int NREQ  = 4;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int IW    = $clog2(NREQ);
    localparam int CNT_W = 8;

    typedef logic [IW-1:0] idx_t;

    // Read tag carried one cycle behind each RAM port.
    typedef struct packed {
        logic valid;
        idx_t index;
    } tag_t;

    typedef struct packed {
        logic found;
        idx_t index;
    } pick_t;

    function automatic idx_t wrap_inc(input idx_t i);
        if (i == idx_t'(NREQ - 1)) return '0;
        return i + idx_t'(1);
    endfunction

    // Scan downward so the last hit written is the nearest one at or after start.
    function automatic pick_t next_req(input logic [NREQ-1:0] req, input idx_t start);
        pick_t p;
        int    j;
        p = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(start) + k) % NREQ;
            if (req[j]) begin
                p.found = 1'b1;
                p.index = idx_t'(j);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/dp_ram_64x8.sv
// Two-port synchronous RAM with registered read data; a port that writes
// in a cycle does not update its read data.
module dp_ram_64x8
    import ram_arb_pkg::*;
(
    input  logic          clk,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] din1,
    output logic [DW-1:0] dout1,
    input  logic          we2,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] din2,
    output logic [DW-1:0] dout2
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we1) mem[addr1] <= din1;
        else     dout1      <= mem[addr1];
        if (we2) mem[addr2] <= din2;
        else     dout2      <= mem[addr2];
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto the two
// ports of a shared RAM, with same-address hazard filtering and 2-cycle reads.
module ram_port_arbiter
    import ram_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     we,
    input  logic [NREQ*AW-1:0]  addr,
    input  logic [NREQ*DW-1:0]  wdata,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rvalid,
    output logic [NREQ*DW-1:0]  rdata,
    output logic [CNT_W-1:0]    conflict_cnt
);

    idx_t            ptr, ptr_nxt;
    pick_t           p1, p2;
    logic            hazard, g1, g2;
    logic [AW-1:0]   a1, a2;
    logic            we1, we2;
    logic [AW-1:0]   ram_addr1, ram_addr2;
    logic [DW-1:0]   din1, din2, dout1, dout2;
    tag_t            tag1, tag2, tag1_nxt, tag2_nxt;
    logic [NREQ-1:0] rv_nxt;
    logic [NREQ*DW-1:0] rdata_nxt;

    always_comb begin
        p1 = next_req(req, ptr);
        // Port 2 continues the circular search just past the port 1 winner.
        p2 = next_req(req & ~(NREQ'(1) << p1.index), wrap_inc(p1.index));
        a1 = addr[p1.index*AW +: AW];
        a2 = addr[p2.index*AW +: AW];
        hazard = p1.found && p2.found && (a1 == a2) && (we[p1.index] || we[p2.index]);
        g1 = p1.found;
        g2 = p2.found && !hazard;

        gnt = '0;
        if (g1) gnt[p1.index] = 1'b1;
        if (g2) gnt[p2.index] = 1'b1;

        we1       = g1 && we[p1.index];
        we2       = g2 && we[p2.index];
        ram_addr1 = g1 ? a1 : '0;
        ram_addr2 = g2 ? a2 : '0;
        din1      = wdata[p1.index*DW +: DW];
        din2      = wdata[p2.index*DW +: DW];

        tag1_nxt = '{valid: g1 && !we[p1.index], index: p1.index};
        tag2_nxt = '{valid: g2 && !we[p2.index], index: p2.index};

        ptr_nxt = ptr;
        if (g2)      ptr_nxt = wrap_inc(p2.index);
        else if (g1) ptr_nxt = wrap_inc(p1.index);
    end

    always_comb begin
        rv_nxt    = '0;
        rdata_nxt = rdata;
        if (tag1.valid) begin
            rv_nxt[tag1.index]                = 1'b1;
            rdata_nxt[tag1.index*DW +: DW]    = dout1;
        end
        if (tag2.valid) begin
            rv_nxt[tag2.index]                = 1'b1;
            rdata_nxt[tag2.index*DW +: DW]    = dout2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= '0;
            tag1         <= '0;
            tag2         <= '0;
            rvalid       <= '0;
            rdata        <= '0;
            conflict_cnt <= '0;
        end else begin
            ptr    <= ptr_nxt;
            tag1   <= tag1_nxt;
            tag2   <= tag2_nxt;
            rvalid <= rv_nxt;
            rdata  <= rdata_nxt;
            if (hazard && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    dp_ram_64x8 u_ram (
        .clk   (clk),
        .we1   (we1),
        .addr1 (ram_addr1),
        .din1  (din1),
        .dout1 (dout1),
        .we2   (we2),
        .addr2 (ram_addr2),
        .din2  (din2),
        .dout2 (dout2)
    );

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one 64x8 dual-port RAM (two independent read/write ports, registered read data, read suppressed on a write cycle) among NREQ requesters. Up to two requests are granted per cycle, one per RAM port. Same-address hazards between the two ports are resolved, and each requester gets its read data back with a fixed latency. The block sits between the local masters and the RAM and owns the RAM instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 6, RAM address width (64 words)
- DW, 8, RAM data width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  request per requester; held until granted
- we  in  NREQ  1 = write, 0 = read; qualified by req
- addr  in  NREQ*AW  per-requester address, slice i = [i*AW +: AW]
- wdata  in  NREQ*DW  per-requester write data
- gnt  out  NREQ  combinational; request i consumed at the clock edge ending a cycle with gnt[i]=1
- rvalid  out  NREQ  one-cycle pulse: read data for requester i is ready
- rdata  out  NREQ*DW  per-requester read-data holding register; updated only with rvalid
- conflict_cnt  out  8  saturating count of port-2 grants dropped for address hazards

## Operation
- Round-robin pointer ptr (index width clog2(NREQ)).
- Port 1 candidate c1 is the first i with req[i]=1, searching from ptr upward modulo NREQ.
- Port 2 candidate c2 is the next requesting index after c1 in the same circular order, excluding c1.
- Hazard: c2 is dropped (gnt stays 0, requester retries) when both candidates exist, addr[c1]==addr[c2], and we[c1] or we[c2] is set. Two reads of the same address are both granted.
- The RAM port 1 fields are driven from c1 and the port 2 fields from c2.
  - Port write enable = granted & we.
  - Ungranted ports issue a read of address 0 and produce no tag.
- ptr update, registered:
  - ptr <= (highest-order granted index in search order) + 1 mod NREQ.
  - With no grant, ptr is unchanged.
- Read tag pipeline: per port, {valid, index} registered at the grant edge (valid = granted & ~we).
  - Next edge: rdata[index] <= port dout, and rvalid[index] pulses in the following cycle.
- Writes produce no response.
- conflict_cnt increments by 1 per dropped c2 and saturates at 255.
- Reset: ptr=0, tag valids=0, rvalid=0, rdata=0, conflict_cnt=0. RAM contents are not reset.
  - Reset asserted mid-operation discards in-flight reads; no rvalid is produced for them.
- Boundaries:
  - A single requester takes port 1 only.
  - With all NREQ requesting, grants advance two per cycle and every requester is served within ceil(NREQ/2) cycles absent hazards.
  - A requester with a write hazard is served no later than the next cycle, because ptr moves past c1.

## Timing
- Cycle T: gnt[i]=1 combinationally from req/we/addr and ptr. The RAM samples at the edge ending T.
- Cycle T+1: RAM dout valid. rdata[i] loads at the edge ending T+1.
- Cycle T+2: rvalid[i]=1 for exactly one cycle, and rdata[i] is stable from T+2 until the next load. Read latency is 2 cycles, grant to rvalid.
- Write visibility:
  - A write granted in T is visible to a read granted in T+1 or later.
  - A read and a write to the same address in the same cycle cannot both be granted.
- Back-to-back grants to the same requester yield back-to-back rvalid pulses.
- The only combinational path is req/we/addr -> gnt; there is none from input to rdata.

## Structure
- Package ram_arb_pkg:
  - Constants NREQ, AW, DW, IW = clog2(NREQ), CNT_W = 8.
  - Typedef of the port tag {valid, index}.
  - Circular-search function that returns the next requesting index from a start position.
- Sub-module dp_ram_64x8:
  - Two-port synchronous RAM.
  - Per port, on posedge clk: if write enable, write; else dout <= mem[addr].
  - Instantiated once, inside the arbiter.

## Test plan
- Reset, then idle: rst pulsed mid-run with a read in flight -> no rvalid; all outputs 0; ptr=0.
- Requester 0 writes 0xA5 to addr 5, then requester 2 reads addr 5 -> gnt[2] in T, rvalid[2] in T+2, rdata[2]=0xA5.
- All four requesters read distinct addresses, ptr=0 -> cycle 1 grants 0 and 1, cycle 2 grants 2 and 3; ptr ends at 0; four rvalids with correct data.
- Requester 1 writes addr 9 and requester 2 reads addr 9 in the same cycle, ptr=1:
  - gnt[1]=1, gnt[2]=0, conflict_cnt=1.
  - Next cycle gnt[2]=1, and the read returns the newly written value.
- Requesters 0 and 3 read addr 12 together -> both granted in the same cycle, both rvalid at T+2 with identical data, conflict_cnt unchanged.
- 300 forced write-write same-address conflicts -> conflict_cnt saturates at 255; every write completes, and the final RAM word equals the last granted write.
